// File: rtl/fact_accel_mm.sv
// Memory-mapped iterative factorial accelerator: one multiply step per busy cycle,
// saturating on overflow, with W1C status, interrupt and busy-cycle counter.
module fact_accel_mm #(
    parameter int NW = 4,
    parameter int RW = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [NW-1:0]   n_reg;
    logic            ie;
    logic            done;
    logic            ovf;
    logic            rej;
    logic [RW-1:0]   result;
    logic [31:0]     cycles;

    logic [RW-1:0]   acc;
    logic [NW-1:0]   cnt;
    logic [RW:0]     mul_q;

    logic            go;
    logic            busy;
    logic            start;
    logic            step;
    logic            finish;

    // Unused upper write-data bits, folded away so they are not flagged as dangling.
    logic            unused_wd;
    assign unused_wd = ^wd[31:NW] ^ wd[2];

    // Saturating multiply: MSB flags overflow, lower RW bits are the clamped product.
    function automatic logic [RW:0] sat_mul(input logic [RW-1:0] x, input logic [NW-1:0] k);
        logic [2*RW-1:0] p;
        p = (2*RW)'(x) * (2*RW)'(k);
        if (|p[2*RW-1:RW])
            sat_mul = {1'b1, {RW{1'b1}}};
        else
            sat_mul = {1'b0, p[RW-1:0]};
    endfunction

    assign go    = we && (a == 3'd1) && wd[0];
    assign mul_q = sat_mul(acc, cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = BUSY;
            BUSY:    if (cnt <= NW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A GO landing on the completion edge still sees BUSY and is rejected.
    always_comb begin
        busy   = (state == BUSY);
        start  = go && !busy;
        step   = busy && (cnt > NW'(1));
        finish = busy && (cnt <= NW'(1));
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc <= {{(RW-1){1'b0}}, 1'b1};
            cnt <= n_reg;
        end else if (step) begin
            acc <= mul_q[RW-1:0];
            cnt <= cnt - NW'(1);
        end
    end

    // Clears are applied before sets so a completion beats a same-edge W1C of done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg  <= '0;
            ie     <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            rej    <= 1'b0;
            result <= '0;
            cycles <= '0;
        end else begin
            if (we && (a == 3'd0))
                n_reg <= wd[NW-1:0];
            if (we && (a == 3'd1))
                ie <= wd[1];
            if (we && (a == 3'd2)) begin
                if (wd[0]) done <= 1'b0;
                if (wd[1]) ovf  <= 1'b0;
                if (wd[3]) rej  <= 1'b0;
            end
            if (start) begin
                cycles <= '0;
                done   <= 1'b0;
                ovf    <= 1'b0;
            end
            if (busy)
                cycles <= cycles + 32'd1;
            if (step && mul_q[RW])
                ovf <= 1'b1;
            if (finish) begin
                result <= acc;
                done   <= 1'b1;
            end
            if (go && busy)
                rej <= 1'b1;
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            3'd0:    rd[NW-1:0] = n_reg;
            3'd1:    rd[1]      = ie;
            3'd2:    rd[3:0]    = {rej, busy, ovf, done};
            3'd3:    rd[RW-1:0] = result;
            3'd4:    rd         = cycles;
            default: rd         = '0;
        endcase
    end

    assign irq = ie && done;

endmodule
